scan_response_checker: RTL

- On-chip counterpart of the non-scan pattern testbench flow.
- Accepts a stream of test patterns, each carrying a PI vector, an expected PO vector and a compare mask.
- Drives the PI vector onto the DUT and strobes the DUT outputs a fixed delay later. Compares only the masked bits, counts failing bits and records the first failing pattern.
- Sits between a pattern source (ROM or DMA) and the DUT (e.g. alu) in the BIST/test wrapper.

---
 rtl/scan_test_pkg.sv | 26 ++
 rtl/sat_counter.sv | 32 +++
 rtl/scan_response_checker.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/scan_test_pkg.sv
// Shared types and timing defaults for the scan response checker.
// Pure declarations; no latency or flow control of its own.
package scan_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int STROBE_DLY_DEF = 4;
    localparam int CYCLE_LEN_DEF  = 10;

    // Vectors wider than 32 bits must be folded by the caller before counting.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds i_inc when i_en and sticks at all-ones.
// One-cycle update latency; no flow control, the caller gates i_en.
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [INC_W-1:0] i_inc,
    output logic [W-1:0]     o_cnt
);
    localparam int SW = ((W > INC_W) ? W : INC_W) + 1;
    localparam logic [SW-1:0] MAX_VAL = {{(SW-W){1'b0}}, {W{1'b1}}};

    logic [W-1:0]  r_cnt;
    logic [SW-1:0] w_sum;

    // Sum is one bit wider than either operand so the carry is never lost.
    assign w_sum = SW'(r_cnt) + SW'(i_inc);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (w_sum > MAX_VAL) ? {W{1'b1}} : w_sum[W-1:0];
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/scan_response_checker.sv
// Applies test patterns to a DUT, strobes its outputs STROBE_DLY+1 cycles after accept and scores masked mismatches.
// One pattern per CYCLE_LEN cycles: pat_ready is high only while idle; after the last pattern it stays low until reset.
module scan_response_checker
    import scan_test_pkg::*;
#(
    parameter int NINPUTS    = 5,
    parameter int NOUTPUTS   = 2,
    parameter int STROBE_DLY = STROBE_DLY_DEF,
    parameter int CYCLE_LEN  = CYCLE_LEN_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pat_valid,
    output logic                pat_ready,
    input  logic [NINPUTS-1:0]  pat_pi,
    input  logic [NOUTPUTS-1:0] pat_xpct,
    input  logic [NOUTPUTS-1:0] pat_mask,
    input  logic                pat_last,
    output logic [NINPUTS-1:0]  dut_pi,
    input  logic [NOUTPUTS-1:0] dut_po,
    output logic                busy,
    output logic                done,
    output logic                fail_seen,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    pat_count,
    output logic [CNT_W-1:0]    first_fail_pat,
    output logic [NOUTPUTS-1:0] first_fail_bits
);
    // Timer can reach CYCLE_LEN+1 when the strobe lands on the last cycle of the slot.
    localparam int TMR_W = $clog2(CYCLE_LEN + 2);
    localparam int POP_W = $clog2(NOUTPUTS + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [NINPUTS-1:0]  r_pi;
    logic [NOUTPUTS-1:0] r_xpct;
    logic [NOUTPUTS-1:0] r_mask;
    logic                r_last;
    logic                r_fail_seen;
    logic [CNT_W-1:0]    r_ffp;
    logic [NOUTPUTS-1:0] r_ffb;

    logic                w_accept;
    logic                w_strobe;
    logic [NOUTPUTS-1:0] w_mism;
    logic [POP_W-1:0]    w_pop;

    always_comb begin
        w_state_nxt = r_state;
        pat_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        w_strobe    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                pat_ready = 1'b1;
                if (pat_valid) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (r_timer == TMR_W'(STROBE_DLY)) w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                busy        = 1'b1;
                w_strobe    = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                // >= so a strobe on the final slot cycle still leaves HOLD after one cycle.
                if (r_timer >= TMR_W'(CYCLE_LEN - 1)) begin
                    w_state_nxt = r_last ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = pat_ready & pat_valid;
    assign w_mism   = (dut_po ^ r_xpct) & r_mask;
    assign w_pop    = POP_W'(popcount(32'(w_mism)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_pi    <= '0;
            r_xpct  <= '0;
            r_mask  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_timer <= TMR_W'(1);
                r_pi    <= pat_pi;
                r_xpct  <= pat_xpct;
                r_mask  <= pat_mask;
                r_last  <= pat_last;
            end else if (busy) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    // Only the first failing pattern is recorded; later failures just add to fail_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_seen <= 1'b0;
            r_ffp       <= '0;
            r_ffb       <= '0;
        end else if (w_strobe && (w_mism != '0) && !r_fail_seen) begin
            r_fail_seen <= 1'b1;
            r_ffp       <= pat_count;
            r_ffb       <= w_mism;
        end
    end

    sat_counter #(
        .W     (CNT_W),
        .INC_W (POP_W)
    ) u_fail_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_strobe),
        .i_inc (w_pop),
        .o_cnt (fail_count)
    );

    sat_counter #(
        .W     (CNT_W),
        .INC_W (1)
    ) u_pat_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_strobe),
        .i_inc (1'b1),
        .o_cnt (pat_count)
    );

    assign dut_pi          = r_pi;
    assign fail_seen       = r_fail_seen;
    assign first_fail_pat  = r_ffp;
    assign first_fail_bits = r_ffb;

endmodule
